// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential 32x32 unsigned multiply / divide unit.
//   One request is accepted at a time. A multiply runs 32 shift-add steps and
//   a divide runs 32 restoring shift-subtract steps. The result is then shown
//   for exactly one cycle.
// Ports:
//   clk    - single clock; all state updates on the rising edge
//   rst    - asynchronous, active-high reset
//   valid  - start request; qualifies mode, in_A and in_B (honoured only in IDLE)
//   mode   - 0 = MUL, 1 = DIV
//   in_A   - multiplicand / dividend (unsigned)
//   in_B   - multiplier / divisor (unsigned)
//   ready  - one-cycle result strobe
//   busy   - high from acceptance through the ready cycle, inclusive
//   out    - MUL: 64-bit product; DIV: {remainder, quotient}; 64'h0 when ready=0
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mode,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic        ready,
  output logic        busy,
  output logic [63:0] out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [4:0]  cnt_r;
  logic        mode_r;
  logic [31:0] opnd_r;        // multiplicand (MUL) or divisor (DIV)
  logic [63:0] acc_r;         // MUL: {upper product, multiplier}; DIV: {remainder, quotient}
  logic [63:0] acc_step_s;
  logic [32:0] mul_sum_s;
  logic [31:0] div_diff_s;
  logic        ready_r;
  logic        busy_r;
  logic [63:0] out_r;

  assign ready = ready_r;
  assign busy  = busy_r;
  assign out   = out_r;

  // One datapath step for the operation in flight.
  always_comb begin
    // 33-bit add so the carry out of the upper half is kept and shifted down.
    mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    // After the left shift the partial remainder is acc_r[63:31] (33 bits).
    // When it is >= the divisor the true difference fits in 32 bits, so a
    // 32-bit subtract of the low bits is exact.
    div_diff_s = acc_r[62:31] - opnd_r;
    acc_step_s = acc_r;
    if (mode_r == 1'b0) begin
      if (acc_r[0] == 1'b1) begin
        acc_step_s = {mul_sum_s, acc_r[31:1]};
      end else begin
        acc_step_s = {1'b0, acc_r[63:1]};
      end
    end else begin
      // A zero divisor always "fits": quotient becomes all ones and the
      // remainder collects the dividend bits unchanged.
      if (acc_r[63:31] >= {1'b0, opnd_r}) begin
        acc_step_s = {div_diff_s, acc_r[30:0], 1'b1};
      end else begin
        acc_step_s = {acc_r[62:0], 1'b0};
      end
    end
  end

  // Next-state selection for the sequencing FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid) begin
          state_next_s = mode ? ST_DIV : ST_MUL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_r == 5'd31) begin
          state_next_s = ST_OUT;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_OUT:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, operand capture, step counter and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      mode_r  <= 1'b0;
      opnd_r  <= 32'd0;
      acc_r   <= 64'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (valid) begin
            cnt_r  <= 5'd0;
            mode_r <= mode;
            // MUL: multiplicand is in_A, multiplier sits in the low half.
            // DIV: divisor is in_B, dividend sits in the low half.
            opnd_r <= mode ? in_B : in_A;
            acc_r  <= {32'd0, (mode ? in_A : in_B)};
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        ST_OUT: begin
          cnt_r <= 5'd0;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Registered outputs: the strobe and result appear the cycle after OUT is
  // reached; busy rises with acceptance and drops after the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      out_r   <= 64'd0;
    end else begin
      ready_r <= (state_r == ST_OUT);
      busy_r  <= (state_next_s != ST_IDLE) || (state_r == ST_OUT);
      if (state_r == ST_OUT) begin
        out_r <= acc_r;
      end else begin
        out_r <= 64'd0;
      end
    end
  end

endmodule
